ppm_tx_multi: RTL and testbench
===============================

PPM_TX_MULTI -- requirements
Module: ppm_tx_multi

Interface
REQ-001 SHALL provide parameter SLOT_CYCLES, default 120, clk cycles per PPM slot (legal 2..65535).
REQ-002 SHALL provide parameter BITS_PER_SYM, default 2, data bits per symbol; M = 2^BITS_PER_SYM slots (legal 1..4).
REQ-003 SHALL provide parameter GUARD_SLOTS, default 0, always-idle slots appended after the M data slots (legal 0..7).
REQ-004 SHALL provide parameter ACTIVE_LOW, default 0, meaning 1 inverts ppm_out (idle high, pulse low).
REQ-005 SHALL have clk  input  1  system clock, rising edge.
REQ-006 SHALL have reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have en  input  1  frame-start enable.
REQ-008 SHALL have sym_data  input  BITS_PER_SYM  symbol value, slot index of the pulse.
REQ-009 SHALL have sym_valid  input  1  sym_data valid.
REQ-010 SHALL have sym_ready  output  1  block can accept a symbol this cycle.
REQ-011 SHALL have ppm_out  output  1  registered PPM waveform.
REQ-012 SHALL have busy  output  1  frame in progress.
REQ-013 SHALL have sym_done  output  1  one-cycle pulse on the last cycle of each frame.
REQ-014 SHALL have sym_count  output  16  frames completed, wraps 0xFFFF->0x0000.

Function
REQ-015 SHALL accept a symbol on a rising edge where sym_valid && sym_ready; sym_data is ignored otherwise.
REQ-016 SHALL contain a one-entry holding register; sym_ready = hold register empty (combinational from state, not from sym_valid).
REQ-017 SHALL use states IDLE and SEND; frame length F = (M + GUARD_SLOTS) * SLOT_CYCLES cycles.
REQ-018 IDLE->SEND when en=1 and holding register full: symbol moves to active register, holding register empties, first frame cycle is the next cycle.
REQ-019 Acceptance while IDLE with en=1 and empty hold SHALL start the frame on the cycle after acceptance (latency 1 cycle to first frame cycle).
REQ-020 Within a frame, slot index s = cycle_in_frame / SLOT_CYCLES; the pulse is asserted for all SLOT_CYCLES cycles of slot s == active symbol; other slots, including guard slots, idle.
REQ-021 On the last frame cycle: sym_done=1, sym_count increments; if hold full and en=1, next frame starts on the following cycle with no idle gap; otherwise go IDLE.
REQ-022 Acceptance on the same cycle as the last frame cycle with hold empty and en=1 SHALL start the new frame back-to-back on the following cycle.
REQ-023 en=0 SHALL NOT abort a frame in progress; it only blocks starting new frames; symbols may still be accepted into the hold register.
REQ-024 In IDLE ppm_out SHALL equal the idle level (0, or 1 when ACTIVE_LOW=1); busy=1 exactly in SEND.
REQ-025 Slot and frame counters SHALL be sized from parameters ($clog2) and wrap to 0 at their terminal counts; no X-propagating comparisons.

Reset
REQ-026 reset_n low SHALL asynchronously force: state IDLE, hold empty, sym_ready=1, ppm_out=idle level, busy=0, sym_done=0, sym_count=0, all counters 0.
REQ-027 Reset asserted mid-frame SHALL truncate the frame immediately; no sym_done, no count; after release, the block behaves as after power-up.

Verification
REQ-028 SLOT_CYCLES=4, BITS=2, GUARD=1, accept 2 at cycle t (IDLE, en=1) -> ppm_out high cycles t+9..t+12 only; sym_done at t+20; sym_count=1.
REQ-029 Same params, hold symbols 0 then 3 back-to-back -> pulses at frame-relative cycles 1..4 and 21+12..21+15; no idle gap; sym_count=2.
REQ-030 en=0, accept 1 -> sym_ready=0, ppm_out idle, busy=0; raise en -> frame starts next cycle, pulse in slot 1.
REQ-031 ACTIVE_LOW=1, BITS=1, symbol 1 -> ppm_out 1 except low during slot 1; idle high.
REQ-032 reset_n low at frame cycle 6 -> ppm_out idle, sym_count=0, sym_ready=1 immediately (async).
REQ-033 Force sym_count=0xFFFF state via 65536 frames (SLOT_CYCLES=2, BITS=1) -> wraps to 0x0000.

Source files
------------

// File: rtl/ppm_tx_multi.sv
// M-ary pulse-position modulator: one pulse of SLOT_CYCLES clocks per frame,
// placed in the slot selected by the symbol, with optional trailing guard slots.
`timescale 1ns/1ps
module ppm_tx_multi #(
  parameter int unsigned SLOT_CYCLES  = 120,
  parameter int unsigned BITS_PER_SYM = 2,
  parameter int unsigned GUARD_SLOTS  = 0,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [BITS_PER_SYM-1:0] sym_data,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic                    ppm_out,
  output logic                    busy,
  output logic                    sym_done,
  output logic [15:0]             sym_count
);

  localparam int unsigned M         = 1 << BITS_PER_SYM;
  localparam int unsigned N_SLOTS   = M + GUARD_SLOTS;
  localparam int unsigned CW        = $clog2(SLOT_CYCLES);
  localparam int unsigned SW        = $clog2(N_SLOTS);
  localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(N_SLOTS - 1);

  if (SLOT_CYCLES < 2 || SLOT_CYCLES > 65535) begin : g_bad_slot_cycles
    $error("ppm_tx_multi: SLOT_CYCLES out of range 2..65535");
  end
  if (BITS_PER_SYM < 1 || BITS_PER_SYM > 4) begin : g_bad_bits
    $error("ppm_tx_multi: BITS_PER_SYM out of range 1..4");
  end
  if (GUARD_SLOTS > 7) begin : g_bad_guard
    $error("ppm_tx_multi: GUARD_SLOTS out of range 0..7");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                  r_state,     w_state_nxt;
  logic [CW-1:0]           r_cyc,       w_cyc_nxt;
  logic [SW-1:0]           r_slot,      w_slot_nxt;
  logic [BITS_PER_SYM-1:0] r_active,    w_active_nxt;
  logic                    r_hold_full, w_hold_full_nxt;
  logic [BITS_PER_SYM-1:0] r_hold_data;
  logic                    r_ppm,       w_ppm_nxt;
  logic [15:0]             r_sym_count;

  logic w_accept;
  logic w_cyc_wrap;
  logic w_last;
  logic w_start;

  assign w_accept   = sym_valid && !r_hold_full;
  assign w_cyc_wrap = (r_cyc == CYC_LAST);
  assign w_last     = (r_state == S_SEND) && w_cyc_wrap && (r_slot == SLOT_LAST);
  // A frame may start from IDLE or directly after the last cycle of the
  // previous one; a symbol arriving in that same cycle bypasses the hold register.
  assign w_start    = en && (r_hold_full || w_accept) && ((r_state == S_IDLE) || w_last);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt     = r_state;
    w_cyc_nxt       = r_cyc;
    w_slot_nxt      = r_slot;
    w_active_nxt    = r_active;
    w_hold_full_nxt = r_hold_full;

    if (w_start) begin
      w_state_nxt     = S_SEND;
      w_cyc_nxt       = '0;
      w_slot_nxt      = '0;
      w_active_nxt    = r_hold_full ? r_hold_data : sym_data;
      w_hold_full_nxt = 1'b0;
    end else begin
      if (w_accept) begin
        w_hold_full_nxt = 1'b1;
      end
      if (w_last) begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = '0;
        w_slot_nxt  = '0;
      end else if (r_state == S_SEND) begin
        w_cyc_nxt = w_cyc_wrap ? '0 : r_cyc + 1'b1;
        if (w_cyc_wrap) begin
          w_slot_nxt = r_slot + 1'b1;
        end
      end
    end

    // Output is registered from next-state values so it lines up with the slot.
    w_ppm_nxt = ((w_state_nxt == S_SEND) && (w_slot_nxt == SW'(w_active_nxt))) ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cyc       <= '0;
      r_slot      <= '0;
      r_active    <= '0;
      r_hold_full <= 1'b0;
      r_ppm       <= ACTIVE_LOW;
      r_sym_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_state     <= w_state_nxt;
      r_cyc       <= w_cyc_nxt;
      r_slot      <= w_slot_nxt;
      r_active    <= w_active_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_ppm       <= w_ppm_nxt;
      if (w_last) begin
        r_sym_count <= r_sym_count + 16'd1;
      end
    end
  end

  // NOTE: hold data has no reset; r_hold_full guards every use of it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold_data <= sym_data;
    end
  end

  assign sym_ready = !r_hold_full;
  assign ppm_out   = r_ppm;
  assign busy      = (r_state == S_SEND);
  assign sym_done  = w_last;
  assign sym_count = r_sym_count;

endmodule

// File: tb/tb_ppm_tx_multi.sv
// Directed bench for ppm_tx_multi: instance A (4-cycle slots, 4 data + 1 guard slot)
// and instance B (2-cycle slots, binary, active-low output).
`timescale 1ns/1ps
module tb_ppm_tx_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        a_en, a_valid, a_ready, a_ppm, a_busy, a_done;
  logic [1:0]  a_data;
  logic [15:0] a_count;

  logic        b_en, b_valid, b_ready, b_ppm, b_busy, b_done;
  logic [0:0]  b_data;
  logic [15:0] b_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  ppm_tx_multi #(
    .SLOT_CYCLES (4),
    .BITS_PER_SYM(2),
    .GUARD_SLOTS (1),
    .ACTIVE_LOW  (1'b0)
  ) dut_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (a_en),
    .sym_data (a_data),
    .sym_valid(a_valid),
    .sym_ready(a_ready),
    .ppm_out  (a_ppm),
    .busy     (a_busy),
    .sym_done (a_done),
    .sym_count(a_count)
  );

  ppm_tx_multi #(
    .SLOT_CYCLES (2),
    .BITS_PER_SYM(1),
    .GUARD_SLOTS (0),
    .ACTIVE_LOW  (1'b1)
  ) dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (b_en),
    .sym_data (b_data),
    .sym_valid(b_valid),
    .sym_ready(b_ready),
    .ppm_out  (b_ppm),
    .busy     (b_busy),
    .sym_done (b_done),
    .sym_count(b_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    a_en = 1'b0; a_valid = 1'b0; a_data = '0;
    b_en = 1'b0; b_valid = 1'b0; b_data = '0;
    step_n(2);

    // Reset state
    check("rst a_ready", a_ready, 1);
    check("rst a_busy",  a_busy,  0);
    check("rst a_ppm",   a_ppm,   0);
    check("rst a_done",  a_done,  0);
    check("rst a_count", a_count, 0);
    check("rst b_ppm",   b_ppm,   1);
    reset_n = 1'b1;
    step();

    // Symbol 2 accepted at t: pulse t+9..t+12, done at t+20
    a_en = 1'b1; a_valid = 1'b1; a_data = 2'd2;
    step();
    a_valid = 1'b0;
    check("t1 ready after bypass", a_ready, 1);
    for (int k = 1; k <= 21; k++) begin
      check($sformatf("t1 ppm k=%0d", k),  a_ppm,  (k >= 9 && k <= 12) ? 1 : 0);
      check($sformatf("t1 done k=%0d", k), a_done, (k == 20) ? 1 : 0);
      check($sformatf("t1 busy k=%0d", k), a_busy, (k <= 20) ? 1 : 0);
      if (k < 21) step();
    end
    check("t1 count", a_count, 1);

    // Back-to-back symbols 0 then 3
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("t2 count after reset", a_count, 0);
    a_valid = 1'b1; a_data = 2'd0;
    step();
    check("t2 ready k=1", a_ready, 1);
    check("t2 ppm k=1",   a_ppm,   1);
    a_data = 2'd3;
    step();
    a_valid = 1'b0;
    check("t2 ready held", a_ready, 0);
    for (int k = 2; k <= 41; k++) begin
      check($sformatf("t2 ppm k=%0d", k),
            a_ppm, ((k >= 1 && k <= 4) || (k >= 33 && k <= 36)) ? 1 : 0);
      check($sformatf("t2 done k=%0d", k), a_done, (k == 20 || k == 40) ? 1 : 0);
      check($sformatf("t2 busy k=%0d", k), a_busy, (k <= 40) ? 1 : 0);
      if (k < 41) step();
    end
    check("t2 count", a_count, 2);
    check("t2 ready end", a_ready, 1);

    // Acceptance on the last frame cycle chains the next frame
    a_valid = 1'b1; a_data = 2'd1;
    step();
    a_valid = 1'b0;
    step_n(19);
    check("t3 done last", a_done, 1);
    check("t3 ready last", a_ready, 1);
    a_valid = 1'b1; a_data = 2'd3;
    step();
    a_valid = 1'b0;
    check("t3 busy no gap", a_busy, 1);
    check("t3 ppm frame start", a_ppm, 0);
    check("t3 count", a_count, 3);
    step_n(11);
    check("t3 ppm before slot3", a_ppm, 0);
    step();
    check("t3 ppm slot3", a_ppm, 1);
    step_n(8);
    check("t3 busy end", a_busy, 0);
    check("t3 count end", a_count, 4);

    // en=0 holds off a frame; en drop mid-frame does not abort
    a_en = 1'b0; a_valid = 1'b1; a_data = 2'd1;
    step();
    a_valid = 1'b0;
    check("t4 ready full", a_ready, 0);
    check("t4 busy idle",  a_busy,  0);
    check("t4 ppm idle",   a_ppm,   0);
    step_n(3);
    check("t4 busy still idle", a_busy, 0);
    check("t4 ppm still idle",  a_ppm,  0);
    a_en = 1'b1;
    step();
    a_en = 1'b0;
    check("t4 busy start", a_busy, 1);
    check("t4 ready free", a_ready, 1);
    step_n(3);
    check("t4 ppm u+4", a_ppm, 0);
    step();
    check("t4 ppm u+5", a_ppm, 1);
    step_n(3);
    check("t4 ppm u+8", a_ppm, 1);
    step();
    check("t4 ppm u+9", a_ppm, 0);
    step_n(11);
    check("t4 busy u+20", a_busy, 1);
    check("t4 done u+20", a_done, 1);
    step();
    check("t4 busy u+21", a_busy, 0);
    check("t4 count", a_count, 5);
    step_n(2);
    check("t4 stays idle en=0", a_busy, 0);

    // Asynchronous reset at frame cycle 6
    a_en = 1'b1; a_valid = 1'b1; a_data = 2'd1;
    step();
    a_valid = 1'b0;
    step_n(6);
    check("t5 ppm before reset", a_ppm, 1);
    reset_n = 1'b0;
    #1;
    check("t5 async ppm",   a_ppm,   0);
    check("t5 async ready", a_ready, 1);
    check("t5 async busy",  a_busy,  0);
    check("t5 async done",  a_done,  0);
    check("t5 async count", a_count, 0);
    step();
    reset_n = 1'b1;
    step_n(20);
    check("t5 no resume busy", a_busy, 0);
    check("t5 no count",       a_count, 0);
    a_valid = 1'b1; a_data = 2'd3;
    step();
    a_valid = 1'b0;
    step_n(11);
    check("t5 post ppm k=12", a_ppm, 0);
    step();
    check("t5 post ppm k=13", a_ppm, 1);
    step_n(8);
    check("t5 post count", a_count, 1);

    // Active-low binary PPM on instance B
    b_en = 1'b1; b_valid = 1'b1; b_data = 1'b1;
    check("t6 ppm idle high", b_ppm, 1);
    step();
    b_valid = 1'b0;
    check("t6 ppm k=1", b_ppm, 1);
    check("t6 busy k=1", b_busy, 1);
    step();
    check("t6 ppm k=2", b_ppm, 1);
    step();
    check("t6 ppm k=3", b_ppm, 0);
    step();
    check("t6 ppm k=4", b_ppm, 0);
    check("t6 done k=4", b_done, 1);
    step();
    check("t6 ppm k=5", b_ppm, 1);
    check("t6 busy k=5", b_busy, 0);
    check("t6 count", b_count, 1);

    // Frame counter wrap from 0xFFFF
    force dut_b.r_sym_count = 16'hFFFF;
    step();
    release dut_b.r_sym_count;
    step();
    b_valid = 1'b1; b_data = 1'b0;
    step();
    b_valid = 1'b0;
    check("t7 ppm slot0 active low", b_ppm, 0);
    step_n(3);
    check("t7 done", b_done, 1);
    step();
    check("t7 wrap count", b_count, 16'h0000);
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    step_n(4);
    check("t7 count after wrap", b_count, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
